// File: rtl/homography_mapper.sv
// Maps a destination pixel coordinate to a sub-pixel source coordinate through a 3x3
// fixed-point homography, with an affine bypass and a bit-serial exact divide.
//
// state | meaning
// IDLE  | ready for a coordinate, latches all job inputs on accept
// MUL   | registers the six coefficient x coordinate products
// SUM   | forms X, Y, W; picks DIV or FIN; arms the dividers
// DIV   | one quotient bit per cycle on both axes
// FIN   | saturate, bounds check, register the result
// OUT   | hold result until the downstream accepts
module homography_mapper #(
  parameter int COORD_WIDTH = 16,
  parameter int COEF_WIDTH  = 32,
  parameter int COEF_FRAC   = 16,
  parameter int SUBPIX_BITS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [COORD_WIDTH-1:0]                dst_x,
  input  logic [COORD_WIDTH-1:0]                dst_y,
  input  logic                                  mode,
  input  logic signed [COEF_WIDTH-1:0]          h11,
  input  logic signed [COEF_WIDTH-1:0]          h12,
  input  logic signed [COEF_WIDTH-1:0]          h13,
  input  logic signed [COEF_WIDTH-1:0]          h21,
  input  logic signed [COEF_WIDTH-1:0]          h22,
  input  logic signed [COEF_WIDTH-1:0]          h23,
  input  logic signed [COEF_WIDTH-1:0]          h31,
  input  logic signed [COEF_WIDTH-1:0]          h32,
  input  logic signed [COEF_WIDTH-1:0]          h33,
  input  logic [COORD_WIDTH-1:0]                src_width,
  input  logic [COORD_WIDTH-1:0]                src_height,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [COORD_WIDTH+SUBPIX_BITS-1:0] src_x,
  output logic signed [COORD_WIDTH+SUBPIX_BITS-1:0] src_y,
  output logic                                  out_oob
);

  localparam int ACC_W  = COEF_WIDTH + COORD_WIDTH + 3;
  localparam int Q_W    = COORD_WIDTH + SUBPIX_BITS;
  localparam int PROD_W = COEF_WIDTH + COORD_WIDTH + 1;
  localparam int DV_W   = ACC_W + SUBPIX_BITS;
  localparam int LIM_W  = ACC_W + Q_W;
  localparam int SH     = COEF_FRAC - SUBPIX_BITS;
  localparam int CNT_W  = $clog2(Q_W);
  localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((1 << (Q_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] QMIN = ~QMAX;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_DIV, S_FIN, S_OUT} state_t;
  state_t state_q, state_d;

  logic [COORD_WIDTH-1:0]        dx_q, dy_q, w_q, hgt_q;
  logic                          mode_q;
  logic signed [COEF_WIDTH-1:0]  h_q [9];
  logic signed [PROD_W-1:0]      p_q [6];
  logic signed [COORD_WIDTH:0]   xs, ys;
  logic signed [ACC_W-1:0]       sum_x_q, sum_y_q, sum_x_c, sum_y_c, sum_w_c;
  logic [ACC_W-1:0]              abs_x_c, abs_y_c, abs_w_c;
  logic [DV_W-1:0]               num_x_c, num_y_c;
  logic [LIM_W-1:0]              lim_c;
  logic                          ovf_x_c, ovf_y_c;
  logic                          wzero_q, neg_x_q, neg_y_q, sat_x_q, sat_y_q;
  logic [ACC_W-1:0]              rem_x_q, rem_y_q, div_d_q;
  logic [Q_W-1:0]                nlo_x_q, nlo_y_q, quo_x_q, quo_y_q;
  logic [ACC_W:0]                trial_x, trial_y;
  logic                          ge_x, ge_y;
  logic [CNT_W-1:0]              cnt_q;
  logic [Q_W:0]                  cx, cy;
  logic signed [Q_W-1:0]         fin_x, fin_y;
  logic                          fin_oob;

  function automatic logic [Q_W:0] clamp_q(input logic signed [ACC_W-1:0] v);
    if (v > QMAX) return {1'b1, QMAX[Q_W-1:0]};
    if (v < QMIN) return {1'b1, QMIN[Q_W-1:0]};
    return {1'b0, v[Q_W-1:0]};
  endfunction

  function automatic logic outside(input logic signed [Q_W-1:0] s,
                                   input logic [COORD_WIDTH-1:0] lim);
    logic [COORD_WIDTH-1:0] ix;
    ix = s[Q_W-1:SUBPIX_BITS];
    return ix[COORD_WIDTH-1] || (ix >= lim);
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign xs = {1'b0, dx_q};
  assign ys = {1'b0, dy_q};

  always_comb begin
    sum_x_c = ACC_W'(p_q[0]) + ACC_W'(p_q[1]) + ACC_W'(h_q[2]);
    sum_y_c = ACC_W'(p_q[2]) + ACC_W'(p_q[3]) + ACC_W'(h_q[5]);
    sum_w_c = ACC_W'(p_q[4]) + ACC_W'(p_q[5]) + ACC_W'(h_q[8]);
    abs_x_c = sum_x_c[ACC_W-1] ? -sum_x_c : sum_x_c;
    abs_y_c = sum_y_c[ACC_W-1] ? -sum_y_c : sum_y_c;
    abs_w_c = sum_w_c[ACC_W-1] ? -sum_w_c : sum_w_c;
    num_x_c = {abs_x_c, {SUBPIX_BITS{1'b0}}};
    num_y_c = {abs_y_c, {SUBPIX_BITS{1'b0}}};
    // quotient would need Q_W or more magnitude bits: saturate instead of dividing
    lim_c   = LIM_W'(abs_w_c) << (Q_W-1);
    ovf_x_c = LIM_W'(num_x_c) >= lim_c;
    ovf_y_c = LIM_W'(num_y_c) >= lim_c;
  end

  always_comb begin
    trial_x = {rem_x_q, nlo_x_q[Q_W-1]};
    trial_y = {rem_y_q, nlo_y_q[Q_W-1]};
    ge_x    = trial_x >= {1'b0, div_d_q};
    ge_y    = trial_y >= {1'b0, div_d_q};
  end

  always_comb begin
    cx = '0;
    cy = '0;
    if (!mode_q) begin
      cx = clamp_q(sum_x_q >>> SH);
      cy = clamp_q(sum_y_q >>> SH);
    end else if (!wzero_q) begin
      cx = {sat_x_q, sat_x_q ? (neg_x_q ? QMIN[Q_W-1:0] : QMAX[Q_W-1:0])
                             : (neg_x_q ? -quo_x_q : quo_x_q)};
      cy = {sat_y_q, sat_y_q ? (neg_y_q ? QMIN[Q_W-1:0] : QMAX[Q_W-1:0])
                             : (neg_y_q ? -quo_y_q : quo_y_q)};
    end
    fin_x   = cx[Q_W-1:0];
    fin_y   = cy[Q_W-1:0];
    fin_oob = wzero_q || cx[Q_W] || cy[Q_W] || outside(fin_x, w_q) || outside(fin_y, hgt_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_MUL;
      S_MUL:  state_d = S_SUM;
      S_SUM:  state_d = (mode_q && sum_w_c != '0) ? S_DIV : S_FIN;
      S_DIV:  if (cnt_q == '0) state_d = S_FIN;
      S_FIN:  state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q <= '0; dy_q <= '0; w_q <= '0; hgt_q <= '0; mode_q <= 1'b0;
      for (int i = 0; i < 9; i++) h_q[i] <= '0;
      for (int i = 0; i < 6; i++) p_q[i] <= '0;
      sum_x_q <= '0; sum_y_q <= '0;
      wzero_q <= 1'b0; neg_x_q <= 1'b0; neg_y_q <= 1'b0;
      sat_x_q <= 1'b0; sat_y_q <= 1'b0;
      rem_x_q <= '0; rem_y_q <= '0; div_d_q <= '0;
      nlo_x_q <= '0; nlo_y_q <= '0; quo_x_q <= '0; quo_y_q <= '0;
      cnt_q <= '0;
      src_x <= '0; src_y <= '0; out_oob <= 1'b0; out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          dx_q <= dst_x; dy_q <= dst_y; mode_q <= mode;
          w_q <= src_width; hgt_q <= src_height;
          h_q[0] <= h11; h_q[1] <= h12; h_q[2] <= h13;
          h_q[3] <= h21; h_q[4] <= h22; h_q[5] <= h23;
          h_q[6] <= h31; h_q[7] <= h32; h_q[8] <= h33;
        end
        S_MUL: begin
          p_q[0] <= PROD_W'(h_q[0]) * PROD_W'(xs);
          p_q[1] <= PROD_W'(h_q[1]) * PROD_W'(ys);
          p_q[2] <= PROD_W'(h_q[3]) * PROD_W'(xs);
          p_q[3] <= PROD_W'(h_q[4]) * PROD_W'(ys);
          p_q[4] <= PROD_W'(h_q[6]) * PROD_W'(xs);
          p_q[5] <= PROD_W'(h_q[7]) * PROD_W'(ys);
        end
        S_SUM: begin
          sum_x_q <= sum_x_c;
          sum_y_q <= sum_y_c;
          wzero_q <= mode_q && (sum_w_c == '0);
          neg_x_q <= sum_x_c[ACC_W-1] ^ sum_w_c[ACC_W-1];
          neg_y_q <= sum_y_c[ACC_W-1] ^ sum_w_c[ACC_W-1];
          sat_x_q <= ovf_x_c;
          sat_y_q <= ovf_y_c;
          // top dividend bits preload the remainder; the low Q_W bits shift in
          rem_x_q <= ACC_W'(num_x_c >> Q_W);
          rem_y_q <= ACC_W'(num_y_c >> Q_W);
          nlo_x_q <= num_x_c[Q_W-1:0];
          nlo_y_q <= num_y_c[Q_W-1:0];
          quo_x_q <= '0;
          quo_y_q <= '0;
          div_d_q <= abs_w_c;
          cnt_q   <= CNT_W'(Q_W-1);
        end
        S_DIV: begin
          rem_x_q <= ge_x ? ACC_W'(trial_x - {1'b0, div_d_q}) : trial_x[ACC_W-1:0];
          rem_y_q <= ge_y ? ACC_W'(trial_y - {1'b0, div_d_q}) : trial_y[ACC_W-1:0];
          nlo_x_q <= nlo_x_q << 1;
          nlo_y_q <= nlo_y_q << 1;
          quo_x_q <= {quo_x_q[Q_W-2:0], ge_x};
          quo_y_q <= {quo_y_q[Q_W-2:0], ge_y};
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIN: begin
          src_x     <= fin_x;
          src_y     <= fin_y;
          out_oob   <= fin_oob;
          out_valid <= 1'b1;
        end
        S_OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_homography_mapper.sv
// Directed and randomized checks of homography_mapper against a plain-arithmetic
// reference model of the source coordinate, out-of-bounds flag and latency.
module tb_homography_mapper;

  localparam longint QMAX = 524287;
  localparam longint QMIN = -524288;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, mode, out_valid, out_ready, out_oob;
  logic [15:0] dst_x, dst_y, src_width, src_height;
  logic signed [31:0] h11, h12, h13, h21, h22, h23, h31, h32, h33;
  logic signed [19:0] src_x, src_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  homography_mapper dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dst_x(dst_x), .dst_y(dst_y), .mode(mode),
    .h11(h11), .h12(h12), .h13(h13), .h21(h21), .h22(h22), .h23(h23),
    .h31(h31), .h32(h32), .h33(h33),
    .src_width(src_width), .src_height(src_height),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_x(src_x), .src_y(src_y), .out_oob(out_oob)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(input longint v, output bit sat);
    sat = (v > QMAX) || (v < QMIN);
    if (v > QMAX) return QMAX;
    if (v < QMIN) return QMIN;
    return v;
  endfunction

  function automatic void ref_model(input bit md, input int c[9], input int dx, input int dy,
                                    input int wb, input int hb, output longint ex,
                                    output longint ey, output bit eoob, output int elat);
    longint x, y, w, vx, vy;
    bit sx, sy;
    x = longint'(c[0]) * dx + longint'(c[1]) * dy + longint'(c[2]);
    y = longint'(c[3]) * dx + longint'(c[4]) * dy + longint'(c[5]);
    w = longint'(c[6]) * dx + longint'(c[7]) * dy + longint'(c[8]);
    if (md && w == 0) begin
      ex = 0; ey = 0; eoob = 1'b1; elat = 3;
      return;
    end
    if (md) begin
      vx = (x * 16) / w;
      vy = (y * 16) / w;
      elat = 23;
    end else begin
      vx = x >>> 12;
      vy = y >>> 12;
      elat = 3;
    end
    ex = clampv(vx, sx);
    ey = clampv(vy, sy);
    eoob = sx || sy || ((ex >>> 4) < 0) || ((ex >>> 4) >= wb) ||
           ((ey >>> 4) < 0) || ((ey >>> 4) >= hb);
  endfunction

  task automatic scramble();
    mode = 1'($urandom);
    dst_x = 16'($urandom); dst_y = 16'($urandom);
    src_width = 16'($urandom); src_height = 16'($urandom);
    h11 = $urandom; h12 = $urandom; h13 = $urandom;
    h21 = $urandom; h22 = $urandom; h23 = $urandom;
    h31 = $urandom; h32 = $urandom; h33 = $urandom;
  endtask

  task automatic apply(input bit md, input int c[9], input int dx, input int dy,
                       input int wb, input int hb);
    mode = md;
    h11 = c[0]; h12 = c[1]; h13 = c[2];
    h21 = c[3]; h22 = c[4]; h23 = c[5];
    h31 = c[6]; h32 = c[7]; h33 = c[8];
    dst_x = 16'(dx); dst_y = 16'(dy);
    src_width = 16'(wb); src_height = 16'(hb);
  endtask

  task automatic run_job(input string name, input bit md, input int c[9], input int dx,
                         input int dy, input int wb, input int hb, input int hold);
    longint ex, ey, hx, hy;
    bit eoob, stable;
    logic ho;
    int elat, lat, n;
    ref_model(md, c, dx, dy, wb, hb, ex, ey, eoob, elat);
    @(negedge clk);
    apply(md, c, dx, dy, wb, hb);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    chk({name, "_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({name, "_latency"}, lat, elat);
    hx = src_x; hy = src_y; ho = out_oob;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (src_x != hx || src_y != hy || out_oob != ho || !out_valid || in_ready) stable = 1'b0;
    end
    if (hold > 0) chk({name, "_hold"}, stable, 1);
    chk({name, "_src_x"}, src_x, ex);
    chk({name, "_src_y"}, src_y, ey);
    chk({name, "_oob"}, out_oob, eoob);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_done_valid"}, out_valid, 0);
    chk({name, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ident[9];
    int c[9];
    bit md, quiet;
    int dx, dy, wb, hb, kind;

    ident = '{65536, 0, 0, 0, 65536, 0, 0, 0, 65536};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    apply(1'b0, ident, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_src_x", src_x, 0);
    chk("reset_src_y", src_y, 0);
    chk("reset_oob", out_oob, 0);
    @(negedge clk);
    rst = 1'b0;

    run_job("ident", 1'b1, ident, 10, 20, 640, 480, 0);
    c = ident; c[8] = 131072;
    run_job("frac", 1'b1, c, 7, 9, 640, 480, 0);
    c = ident; c[2] = 32'hFFFB0000;
    run_job("affine_neg", 1'b0, c, 3, 0, 640, 480, 0);
    c = ident; c[6] = 0; c[7] = 0; c[8] = 0;
    run_job("w_zero", 1'b1, c, 5, 5, 640, 480, 0);
    run_job("backpressure", 1'b1, ident, 10, 20, 640, 480, 10);
    run_job("after_bp", 1'b1, ident, 30, 40, 640, 480, 0);

    // reset while the divider is eight cycles in
    @(negedge clk);
    apply(1'b1, ident, 10, 20, 640, 480);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_src_x", src_x, 0);
    chk("mid_rst_src_y", src_y, 0);
    chk("mid_rst_oob", out_oob, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    chk("mid_rst_no_output", quiet, 1);
    run_job("post_rst", 1'b1, ident, 10, 20, 640, 480, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      md = 1'($urandom);
      c[0] = 65536 + int'($urandom_range(0, 32768)) - 16384;
      c[1] = int'($urandom_range(0, 8192)) - 4096;
      c[2] = (int'($urandom_range(0, 400)) - 200) * 65536;
      c[3] = int'($urandom_range(0, 8192)) - 4096;
      c[4] = 65536 + int'($urandom_range(0, 32768)) - 16384;
      c[5] = (int'($urandom_range(0, 400)) - 200) * 65536;
      c[6] = int'($urandom_range(0, 128)) - 64;
      c[7] = int'($urandom_range(0, 128)) - 64;
      c[8] = 65536 + int'($urandom_range(0, 32768)) - 16384;
      if (kind == 0) begin
        for (int k = 0; k < 9; k++) c[k] = int'($urandom);
      end else if (kind == 1) begin
        md = 1'b1; c[6] = 0; c[7] = 0; c[8] = 0;
      end else if (kind == 2) begin
        c[8] = int'($urandom_range(0, 64)) - 32;
      end
      dx = (kind == 3) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 700));
      dy = int'($urandom_range(0, 700));
      wb = int'($urandom_range(1, 800));
      hb = int'($urandom_range(1, 800));
      run_job("random", md, c, dx, dy, wb, hb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/homography_mapper.md
# homography_mapper

Parametrised successor to the team's perspective coordinate mapper. For each destination pixel it accepts a coordinate over a valid/ready handshake and computes the source coordinate with sub-pixel precision (X/W, Y/W). It supports affine (no divide) and perspective modes, uses signed fixed-point coefficients, and performs an exact multi-cycle signed divide. It sits between the output raster counter and the bilinear sampler of the warp path.

## Interface
- COORD_WIDTH, 16: unsigned destination coordinate width; integer width of source coordinates.
- COEF_WIDTH, 32: signed two's-complement coefficient width.
- COEF_FRAC, 16: fractional bits of each coefficient; must be ≥ SUBPIX_BITS.
- SUBPIX_BITS, 4: fractional bits of src_x/src_y.
- Derived: ACC_W = COEF_WIDTH+COORD_WIDTH+3; Q_W = COORD_WIDTH+SUBPIX_BITS.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  coordinate request.
- in_ready  out  1  high only in IDLE.
- dst_x, dst_y  in  COORD_WIDTH  unsigned destination coordinate.
- mode  in  1  0 = affine (W ignored), 1 = perspective.
- h11..h33  in  COEF_WIDTH each  signed Q(COEF_WIDTH-COEF_FRAC).COEF_FRAC matrix.
- src_width, src_height  in  COORD_WIDTH  source image bounds.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- src_x, src_y  out  Q_W  signed, SUBPIX_BITS fractional bits.
- out_oob  out  1  result outside the source image, saturated, or W = 0.

## Operation
- States: IDLE → MUL → SUM → (DIV, perspective with W≠0 only) → FIN → OUT → IDLE.
- IDLE: on in_valid && in_ready, latch dst_x, dst_y, mode, all nine coefficients, and both bounds. Later input changes have no effect on the job in flight.
- MUL: register six products. Each is coefficient × zero-extended coordinate, signed, COEF_WIDTH+COORD_WIDTH+1 bits.
- SUM: X = h11·x+h12·y+h13, Y = h21·x+h22·y+h23, W = h31·x+h32·y+h33. All are ACC_W signed, with h13/h23/h33 sign-extended.
  - mode = 1 and W = 0: go to FIN with src = 0 and oob = 1.
  - mode = 1 and W ≠ 0: go to DIV.
  - mode = 0: go to FIN.
- DIV: two restoring dividers share the divisor |W|, with dividends |X|<<SUBPIX_BITS and |Y|<<SUBPIX_BITS. They produce one quotient bit per cycle for Q_W cycles.
  - Quotient sign = sign(N) XOR sign(W); result truncates toward zero.
  - Overflow precheck in the SUM→DIV transition: if |N| ≥ |W|<<(Q_W-1), that axis saturates.
- Affine result: src = X >>> (COEF_FRAC-SUBPIX_BITS), an arithmetic shift that floors.
- FIN saturation: clamp each axis to [-2^(Q_W-1), 2^(Q_W-1)-1]. Any clamp sets oob.
- FIN bounds check: with ix = src_x >>> SUBPIX_BITS, set oob if ix < 0 or ix ≥ src_width. Same rule for y against src_height.
- FIN registers src_x, src_y, out_oob and sets out_valid.
- OUT: hold all outputs stable while out_valid && !out_ready. On the handshake, clear out_valid and return to IDLE; the next accept is possible on the following cycle.
- Out-of-bounds results are still delivered (out_valid = 1, out_oob = 1); they are never dropped.

## Timing
- Reset (async, any state): state = IDLE, in_ready = 1, out_valid = 0, src_x = src_y = 0, out_oob = 0, all pipeline and divider registers cleared.
- Let E0 be the accept edge.
  - Perspective with W ≠ 0: out_valid rises at E0+Q_W+3 (23 cycles at defaults).
  - Affine, or W = 0: out_valid rises at E0+3.
- Throughput: one result per (latency + 1 + out_ready wait) cycles. No overlap between jobs.
- Reset asserted mid-job: the job is discarded and no out_valid is produced for it. After release, in_ready = 1 on the first edge.
- in_valid while in_ready = 0: ignored, no queueing. The requester holds its request.

## Test plan
- **Identity, perspective:** h11 = h22 = h33 = 0x00010000, others 0, dst = (10, 20), bounds 640×480 → src_x = 160, src_y = 320, oob = 0; out_valid exactly 23 cycles after accept.
- **Fractional perspective:** identity but h33 = 0x00020000, dst = (7, 9) → src_x = 56 (3.5), src_y = 72 (4.5), oob = 0.
- **Affine negative translation:** mode = 0, h11 = h22 = 1.0, h13 = 0xFFFB0000, dst = (3, 0) → src_x = -32, oob = 1, latency 3.
- **W = 0:** mode = 1, h31 = h32 = h33 = 0, dst = (5, 5) → src_x = src_y = 0, oob = 1, latency 3.
- **Backpressure:** out_ready low for 10 cycles after out_valid → src and oob constant, in_ready = 0. After the release handshake, in_ready = 1 on the next cycle and a new coordinate is accepted.
- **Reset mid-DIV:** assert rst 8 cycles into DIV → out_valid stays 0 and outputs are zero. After release, the identity job completes normally with the 23-cycle latency.
